// File: rtl/unified_cache_mem_scheduler.sv
// Purpose : arbitrates the unified cache's single to-mem port between NUM_BANK
//           miss requesters and NUM_BANK writeback requesters. Critical requests
//           win over non-critical, misses win over writebacks unless writebacks
//           have lost STARVATION_LIMIT selections, and each class is round-robin.
//           The winning packet is held in an output register until memory acks it.
// Ports   :
//   clk_in, reset_in (async, active-low)
//   miss_request_*_flatted_in / miss_request_ack_flatted_out : miss requesters
//   wb_request_*_flatted_in   / wb_request_ack_flatted_out   : writeback requesters
//   to_mem_packet_out, to_mem_packet_valid_out, to_mem_packet_ack_in : memory side

module unified_cache_mem_scheduler #(
  parameter int unsigned NUM_BANK         = 4,
  parameter int unsigned PACKET_WIDTH     = 64,
  parameter int unsigned STARVATION_LIMIT = 16
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic [NUM_BANK*PACKET_WIDTH-1:0] miss_request_flatted_in,
  input  logic [NUM_BANK-1:0]              miss_request_valid_flatted_in,
  input  logic [NUM_BANK-1:0]              miss_request_critical_flatted_in,
  output logic [NUM_BANK-1:0]              miss_request_ack_flatted_out,
  input  logic [NUM_BANK*PACKET_WIDTH-1:0] wb_request_flatted_in,
  input  logic [NUM_BANK-1:0]              wb_request_valid_flatted_in,
  input  logic [NUM_BANK-1:0]              wb_request_critical_flatted_in,
  output logic [NUM_BANK-1:0]              wb_request_ack_flatted_out,
  output logic [PACKET_WIDTH-1:0]          to_mem_packet_out,
  output logic                             to_mem_packet_valid_out,
  input  logic                             to_mem_packet_ack_in
);

  localparam int unsigned PTR_W = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
  localparam int unsigned CNT_W = $clog2(STARVATION_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVATION_LIMIT);
  localparam logic [PTR_W:0]   NB_EXT    = (PTR_W + 1)'(NUM_BANK);
  localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(NUM_BANK - 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                  r_state;
  logic [PTR_W-1:0]        r_ptr_miss;
  logic [PTR_W-1:0]        r_ptr_wb;
  logic [CNT_W-1:0]        r_starve_cnt;
  logic [PACKET_WIDTH-1:0] r_packet;
  logic                    r_valid;
  logic [NUM_BANK-1:0]     r_miss_ack;
  logic [NUM_BANK-1:0]     r_wb_ack;

  logic                    w_any_crit;
  logic                    w_any_valid;
  logic [NUM_BANK-1:0]     w_miss_cand;
  logic [NUM_BANK-1:0]     w_wb_cand;
  logic                    w_sel_wb;
  logic [NUM_BANK-1:0]     w_cand;
  logic [PTR_W-1:0]        w_ptr;
  logic [PTR_W:0]          w_idx_sum;
  logic                    w_found;
  logic [PTR_W-1:0]        w_win_idx;
  logic [PTR_W-1:0]        w_next_ptr;
  logic [NUM_BANK-1:0]     w_win_onehot;
  logic [PACKET_WIDTH-1:0] w_win_pkt;

  // Candidate filtering and class choice
  always_comb begin
    w_any_crit  = (|(miss_request_valid_flatted_in & miss_request_critical_flatted_in)) |
                  (|(wb_request_valid_flatted_in & wb_request_critical_flatted_in));
    w_any_valid = (|miss_request_valid_flatted_in) | (|wb_request_valid_flatted_in);
    w_miss_cand = w_any_crit ? (miss_request_valid_flatted_in & miss_request_critical_flatted_in)
                             : miss_request_valid_flatted_in;
    w_wb_cand   = w_any_crit ? (wb_request_valid_flatted_in & wb_request_critical_flatted_in)
                             : wb_request_valid_flatted_in;
    w_sel_wb    = ((r_starve_cnt == CNT_LIMIT) && (|w_wb_cand)) || !(|w_miss_cand);
    w_cand      = w_sel_wb ? w_wb_cand : w_miss_cand;
    w_ptr       = w_sel_wb ? r_ptr_wb : r_ptr_miss;
  end

  // Round-robin search: first candidate at or above the class pointer, wrapping
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_idx_sum = '0;
    for (int unsigned i = 0; i < NUM_BANK; i++) begin
      w_idx_sum = {1'b0, w_ptr} + (PTR_W + 1)'(i);
      if (w_idx_sum >= NB_EXT) begin
        w_idx_sum = w_idx_sum - NB_EXT;
      end
      if (!w_found && w_cand[PTR_W'(w_idx_sum)]) begin
        w_found   = 1'b1;
        w_win_idx = PTR_W'(w_idx_sum);
      end
    end
  end

  // Winner packet mux, next pointer and ack one-hot
  always_comb begin
    w_win_pkt = '0;
    for (int unsigned b = 0; b < NUM_BANK; b++) begin
      if (PTR_W'(b) == w_win_idx) begin
        w_win_pkt = w_sel_wb ? wb_request_flatted_in[b*PACKET_WIDTH +: PACKET_WIDTH]
                             : miss_request_flatted_in[b*PACKET_WIDTH +: PACKET_WIDTH];
      end
    end
    w_next_ptr   = (w_win_idx == LAST_BANK) ? '0 : PTR_W'(w_win_idx + 1'b1);
    w_win_onehot = NUM_BANK'(1) << w_win_idx;
  end

  // IDLE/HOLD control with registered packet, valid and ack pulses
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state      <= S_IDLE;
      r_ptr_miss   <= '0;
      r_ptr_wb     <= '0;
      r_starve_cnt <= '0;
      r_packet     <= '0;
      r_valid      <= 1'b0;
      r_miss_ack   <= '0;
      r_wb_ack     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_miss_ack <= '0;
          r_wb_ack   <= '0;
          if (w_any_valid) begin
            r_packet <= w_win_pkt;
            r_valid  <= 1'b1;
            r_state  <= S_HOLD;
            if (w_sel_wb) begin
              r_wb_ack     <= w_win_onehot;
              r_ptr_wb     <= w_next_ptr;
              r_starve_cnt <= '0;
            end else begin
              r_miss_ack <= w_win_onehot;
              r_ptr_miss <= w_next_ptr;
              // only count misses that actually kept a writeback waiting
              if ((|wb_request_valid_flatted_in) && (r_starve_cnt != CNT_LIMIT)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
              end
            end
          end
        end
        S_HOLD: begin
          r_miss_ack <= '0;
          r_wb_ack   <= '0;
          if (to_mem_packet_ack_in) begin
            r_packet <= '0;
            r_valid  <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign to_mem_packet_out            = r_packet;
  assign to_mem_packet_valid_out      = r_valid;
  assign miss_request_ack_flatted_out = r_miss_ack;
  assign wb_request_ack_flatted_out   = r_wb_ack;

endmodule

// File: tb/tb_unified_cache_mem_scheduler.sv
// Self-checking bench for unified_cache_mem_scheduler: directed scenarios plus
// randomized traffic checked against a behavioural arbitration model.

module tb_unified_cache_mem_scheduler;

  localparam int NB  = 4;
  localparam int PW  = 32;
  localparam int LIM = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NB*PW-1:0]  miss_pkt, wb_pkt;
  logic [NB-1:0]     miss_v, miss_c, wb_v, wb_c;
  logic [NB-1:0]     miss_ack, wb_ack;
  logic [PW-1:0]     mem_pkt;
  logic              mem_valid;
  logic              mem_ack;

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_ptr_miss, m_ptr_wb, m_starve;

  always #5 clk = ~clk;

  unified_cache_mem_scheduler #(
    .NUM_BANK(NB), .PACKET_WIDTH(PW), .STARVATION_LIMIT(LIM)
  ) dut (
    .clk_in                          (clk),
    .reset_in                        (rst_n),
    .miss_request_flatted_in         (miss_pkt),
    .miss_request_valid_flatted_in   (miss_v),
    .miss_request_critical_flatted_in(miss_c),
    .miss_request_ack_flatted_out    (miss_ack),
    .wb_request_flatted_in           (wb_pkt),
    .wb_request_valid_flatted_in     (wb_v),
    .wb_request_critical_flatted_in  (wb_c),
    .wb_request_ack_flatted_out      (wb_ack),
    .to_mem_packet_out               (mem_pkt),
    .to_mem_packet_valid_out         (mem_valid),
    .to_mem_packet_ack_in            (mem_ack)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    miss_pkt = '0; wb_pkt = '0;
    miss_v = '0; miss_c = '0; wb_v = '0; wb_c = '0;
    mem_ack = 1'b0;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    clear_inputs();
    tick();
    rst_n = 1'b1;
    m_ptr_miss = 0; m_ptr_wb = 0; m_starve = 0;
  endtask

  task automatic raise(input bit is_wb, input int b, input bit crit);
    logic [PW-1:0] p;
    p = $urandom;
    if (is_wb) begin
      wb_v[b] = 1'b1; wb_c[b] = crit; wb_pkt[b*PW +: PW] = p;
    end else begin
      miss_v[b] = 1'b1; miss_c[b] = crit; miss_pkt[b*PW +: PW] = p;
    end
  endtask

  // Arbitration rules applied to the currently driven requests
  function automatic void predict(output bit is_wb, output int bank);
    logic [NB-1:0] mc, wc, cand;
    bit crit;
    int p;
    crit = ((miss_v & miss_c) != 0) || ((wb_v & wb_c) != 0);
    mc = crit ? (miss_v & miss_c) : miss_v;
    wc = crit ? (wb_v & wb_c) : wb_v;
    if (m_starve == LIM && wc != 0) is_wb = 1'b1;
    else if (mc != 0)               is_wb = 1'b0;
    else                            is_wb = 1'b1;
    cand = is_wb ? wc : mc;
    p = is_wb ? m_ptr_wb : m_ptr_miss;
    bank = -1;
    for (int i = NB - 1; i >= 0; i--) begin
      if (cand[(p + i) % NB]) bank = (p + i) % NB;
    end
  endfunction

  // One full issue: grant edge, optional backpressure cycles, memory ack
  task automatic do_issue(input int hold, input int inj_bank, input bit inj_drop,
                          output bit obs_wb, output int obs_bank);
    bit            e_wb;
    int            e_b;
    bit            saw_wb;
    logic [PW-1:0] e_pkt;
    logic [NB-1:0] e_mack, e_wack;
    predict(e_wb, e_b);
    saw_wb = (wb_v != 0);
    e_pkt  = e_wb ? wb_pkt[e_b*PW +: PW] : miss_pkt[e_b*PW +: PW];
    e_mack = '0; e_wack = '0;
    if (e_wb) e_wack[e_b] = 1'b1; else e_mack[e_b] = 1'b1;
    mem_ack = 1'b0;
    tick();
    total++;
    if (mem_valid !== 1'b1 || mem_pkt !== e_pkt)
      $display("FAIL grant_pkt: got v=%0b pkt=%h want v=1 pkt=%h", mem_valid, mem_pkt, e_pkt);
    if (mem_valid !== 1'b1 || mem_pkt !== e_pkt) bad++;
    total++;
    if (miss_ack !== e_mack || wb_ack !== e_wack) begin
      $display("FAIL grant_ack: got miss=%b wb=%b want miss=%b wb=%b", miss_ack, wb_ack, e_mack, e_wack);
      bad++;
    end
    obs_wb = (wb_ack != 0);
    obs_bank = -1;
    for (int b = 0; b < NB; b++) if (miss_ack[b] || wb_ack[b]) obs_bank = b;
    // model update
    if (e_wb) begin
      m_ptr_wb = (e_b + 1) % NB; m_starve = 0;
    end else begin
      m_ptr_miss = (e_b + 1) % NB;
      if (saw_wb && m_starve < LIM) m_starve++;
    end
    // requester saw its ack and withdraws
    if (e_wb) wb_v[e_b] = 1'b0; else miss_v[e_b] = 1'b0;
    for (int k = 0; k < hold; k++) begin
      if (k == 0 && inj_bank >= 0) raise(1'b0, inj_bank, 1'b0);
      if (k == 1 && inj_drop) miss_v[inj_bank] = 1'b0;
      tick();
      total++;
      if (mem_valid !== 1'b1 || mem_pkt !== e_pkt || miss_ack !== '0 || wb_ack !== '0) begin
        $display("FAIL hold_stable: got v=%0b pkt=%h acks=%b/%b want v=1 pkt=%h acks=0",
                 mem_valid, mem_pkt, miss_ack, wb_ack, e_pkt);
        bad++;
      end
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    total++;
    if (mem_valid !== 1'b0 || mem_pkt !== '0 || miss_ack !== '0 || wb_ack !== '0) begin
      $display("FAIL release: got v=%0b pkt=%h acks=%b/%b want all 0", mem_valid, mem_pkt, miss_ack, wb_ack);
      bad++;
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (mem_valid !== 1'b0 || mem_pkt !== '0 || miss_ack !== '0 || wb_ack !== '0) begin
      $display("FAIL %s: got v=%0b pkt=%h acks=%b/%b want all 0", name, mem_valid, mem_pkt, miss_ack, wb_ack);
      bad++;
    end
  endtask

  task automatic test_reset;
    apply_reset();
    check_idle("reset_state");
    raise(1'b0, 0, 1'b0);
    tick();
    total++;
    if (mem_valid !== 1'b1) begin
      $display("FAIL reset_pre_grant: got v=%0b want v=1", mem_valid);
      bad++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("reset_async");
    tick();
    clear_inputs();
    rst_n = 1'b1;
    m_ptr_miss = 0; m_ptr_wb = 0; m_starve = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("reset_quiet");
    end
  endtask

  task automatic test_miss_rr;
    bit ow; int ob;
    apply_reset();
    for (int b = 0; b < NB; b++) raise(1'b0, b, 1'b0);
    for (int g = 0; g < 5; g++) begin
      do_issue(0, -1, 1'b0, ow, ob);
      total++;
      if (ow !== 1'b0 || ob != g % NB) begin
        $display("FAIL miss_rr_order: got wb=%0b bank=%0d want wb=0 bank=%0d", ow, ob, g % NB);
        bad++;
      end
      if (ob >= 0) raise(1'b0, ob, 1'b0);
    end
  endtask

  task automatic test_critical;
    bit ow; int ob;
    bit exp_wb[5] = '{1, 0, 0, 0, 0};
    int exp_b[5]  = '{2, 0, 1, 2, 3};
    apply_reset();
    for (int b = 0; b < NB; b++) raise(1'b0, b, 1'b0);
    raise(1'b1, 2, 1'b1);
    for (int g = 0; g < 5; g++) begin
      do_issue(0, -1, 1'b0, ow, ob);
      total++;
      if (ow !== exp_wb[g] || ob != exp_b[g]) begin
        $display("FAIL critical_order: got wb=%0b bank=%0d want wb=%0b bank=%0d", ow, ob, exp_wb[g], exp_b[g]);
        bad++;
      end
    end
  endtask

  task automatic test_starvation;
    bit ow; int ob;
    bit exp_wb[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int exp_b[9]  = '{0, 1, 2, 1, 3, 0, 1, 1, 2};
    apply_reset();
    for (int b = 0; b < NB; b++) raise(1'b0, b, 1'b0);
    raise(1'b1, 1, 1'b0);
    for (int g = 0; g < 9; g++) begin
      do_issue(0, -1, 1'b0, ow, ob);
      total++;
      if (ow !== exp_wb[g] || ob != exp_b[g]) begin
        $display("FAIL starve_order: got wb=%0b bank=%0d want wb=%0b bank=%0d", ow, ob, exp_wb[g], exp_b[g]);
        bad++;
      end
      if (ob >= 0) raise(ow, ob, 1'b0);
    end
  endtask

  task automatic test_backpressure;
    bit ow; int ob;
    int exp_b[3] = '{0, 1, 2};
    apply_reset();
    raise(1'b0, 0, 1'b0);
    raise(1'b0, 1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      do_issue((g == 0) ? 10 : 0, (g == 0) ? 2 : -1, 1'b0, ow, ob);
      total++;
      if (ow !== 1'b0 || ob != exp_b[g]) begin
        $display("FAIL backpressure_order: got wb=%0b bank=%0d want wb=0 bank=%0d", ow, ob, exp_b[g]);
        bad++;
      end
    end
  endtask

  task automatic test_withdraw;
    bit ow; int ob;
    apply_reset();
    raise(1'b0, 0, 1'b0);
    do_issue(3, 3, 1'b1, ow, ob);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle("withdraw_no_grant");
    end
  endtask

  task automatic test_random;
    bit ow; int ob;
    apply_reset();
    for (int it = 0; it < 300; it++) begin
      for (int b = 0; b < NB; b++) begin
        if (!miss_v[b] && $urandom_range(0, 2) == 0) raise(1'b0, b, $urandom_range(0, 3) == 0);
        if (!wb_v[b]   && $urandom_range(0, 2) == 0) raise(1'b1, b, $urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 7) == 0) miss_v[$urandom_range(0, NB - 1)] = 1'b0;
      if ($urandom_range(0, 7) == 0) wb_v[$urandom_range(0, NB - 1)] = 1'b0;
      if (miss_v != 0 || wb_v != 0) begin
        do_issue($urandom_range(0, 2), -1, 1'b0, ow, ob);
      end else begin
        tick();
        check_idle("random_idle");
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_miss_rr();
    test_critical();
    test_starvation();
    test_backpressure();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
